// File: rtl/systolic_array_pkg.sv
// Shared definitions for the tiled systolic-array scheduler.
// Provides the one-hot controller state type with its bit indices and the
// default operand/accumulator widths used by the scheduler and its drain
// sequencer.
package systolic_array_pkg;

   localparam int SA_DIM_WIDTH = 16;
   localparam int SA_ACC_WIDTH = 32;

   localparam int SA_IDLE_B   = 0;
   localparam int SA_CLEAR_B  = 1;
   localparam int SA_STREAM_B = 2;
   localparam int SA_FLUSH_B  = 3;
   localparam int SA_DRAIN_B  = 4;
   localparam int SA_FINI_B   = 5;

   typedef enum logic [5:0] {
      SA_IDLE   = 6'b000001,
      SA_CLEAR  = 6'b000010,
      SA_STREAM = 6'b000100,
      SA_FLUSH  = 6'b001000,
      SA_DRAIN  = 6'b010000,
      SA_FINI   = 6'b100000
   } systolic_array_state_t;

endpackage

// File: rtl/sa_tile_scheduler_if.sv
// Array-side bus of the tile scheduler: operand feed handshake, systolic
// array control strobes, the accumulator bank and the result write channel.
// master: the scheduler (drives feed_ready, arr_*, wr_valid/wr_addr/wr_data).
// slave:  the feeders, array and output buffer around it.
interface sa_tile_scheduler_if #(
   parameter int TILE_DIM   = 4,
   parameter int ACC_WIDTH  = 32,
   parameter int ADDR_WIDTH = 16
);
   logic                                   feed_valid;
   logic                                   feed_ready;
   logic                                   arr_enb;
   logic                                   arr_clear;
   logic                                   arr_zero_in;
   logic [TILE_DIM*TILE_DIM*ACC_WIDTH-1:0] arr_out;
   logic                                   wr_valid;
   logic                                   wr_ready;
   logic [ADDR_WIDTH-1:0]                  wr_addr;
   logic [ACC_WIDTH-1:0]                   wr_data;

   modport master (
      input  feed_valid, arr_out, wr_ready,
      output feed_ready, arr_enb, arr_clear, arr_zero_in,
      output wr_valid, wr_addr, wr_data
   );

   modport slave (
      output feed_valid, arr_out, wr_ready,
      input  feed_ready, arr_enb, arr_clear, arr_zero_in,
      input  wr_valid, wr_addr, wr_data
   );
endinterface

// File: rtl/sa_drain_sequencer.sv
// Drains the T*T accumulator bank of one tile to the output buffer.
// Ports: clk/rst; drain_go (held high by the scheduler for the whole drain);
// blk_row/blk_col/n_tiles locate the tile in the output matrix; arr_out is the
// accumulator bank; wr_valid/wr_ready/wr_addr/wr_data is the write channel;
// drain_last pulses when the final element of the tile is accepted.
module sa_drain_sequencer
   import systolic_array_pkg::*;
#(
   parameter int TILE_DIM   = 4,
   parameter int ACC_WIDTH  = SA_ACC_WIDTH,
   parameter int ADDR_WIDTH = 16,
   parameter int DIM_WIDTH  = SA_DIM_WIDTH
) (
   input  logic                                   clk,
   input  logic                                   rst,
   input  logic                                   drain_go,
   input  logic [DIM_WIDTH-1:0]                   blk_row,
   input  logic [DIM_WIDTH-1:0]                   blk_col,
   input  logic [DIM_WIDTH-1:0]                   n_tiles,
   input  logic [TILE_DIM*TILE_DIM*ACC_WIDTH-1:0] arr_out,
   input  logic                                   wr_ready,
   output logic                                   wr_valid,
   output logic [ADDR_WIDTH-1:0]                  wr_addr,
   output logic [ACC_WIDTH-1:0]                   wr_data,
   output logic                                   drain_last
);
   localparam int SW = (TILE_DIM > 1) ? $clog2(TILE_DIM) : 1;
   localparam logic [SW-1:0] SUB_LAST = SW'(TILE_DIM - 1);

   // Element index is kept as row/column sub-counters so no divider is
   // needed when TILE_DIM is not a power of two.
   logic [SW-1:0]         row_cnt;
   logic [SW-1:0]         col_cnt;
   logic                  beat;
   int                    elem;
   logic [ADDR_WIDTH-1:0] pitch;
   logic [ADDR_WIDTH-1:0] row_addr;
   logic [ADDR_WIDTH-1:0] col_addr;

   assign wr_valid   = drain_go;
   assign beat       = drain_go && wr_ready;
   assign drain_last = beat && (row_cnt == SUB_LAST) && (col_cnt == SUB_LAST);

   // Counters sit at element 0 whenever no drain is running, so every tile
   // starts cleanly; they only advance on an accepted beat.
   always_ff @(posedge clk) begin
      if (rst || !drain_go) begin
         row_cnt <= '0;
         col_cnt <= '0;
      end else if (beat) begin
         if (col_cnt == SUB_LAST) begin
            col_cnt <= '0;
            row_cnt <= (row_cnt == SUB_LAST) ? '0 : row_cnt + SW'(1);
         end else begin
            col_cnt <= col_cnt + SW'(1);
         end
      end
   end

   assign elem    = int'(row_cnt) * TILE_DIM + int'(col_cnt);
   assign wr_data = arr_out[elem*ACC_WIDTH +: ACC_WIDTH];

   // Row-major address in the full C matrix; all arithmetic wraps at
   // ADDR_WIDTH bits.
   assign pitch    = ADDR_WIDTH'(n_tiles) * ADDR_WIDTH'(TILE_DIM);
   assign row_addr = ADDR_WIDTH'(blk_row) * ADDR_WIDTH'(TILE_DIM) + ADDR_WIDTH'(row_cnt);
   assign col_addr = ADDR_WIDTH'(blk_col) * ADDR_WIDTH'(TILE_DIM) + ADDR_WIDTH'(col_cnt);
   assign wr_addr  = row_addr * pitch + col_addr;

endmodule

// File: rtl/sa_tile_scheduler.sv
// Sequences a tiled GEMM over a TILE_DIM x TILE_DIM systolic array: for each
// output tile (row-major) it clears the accumulators, streams k_len operand
// beats, flushes the skew pipeline for 2*(T-1) cycles and drains the results.
// Ports: clk/rst (sync, active-high); start with m_tiles/n_tiles/k_len
// latched in idle; busy and a one-cycle done; bus carries the feed handshake,
// array strobes, accumulator bank and write channel; blk_row_idx/blk_col_idx
// report the tile being processed.
module sa_tile_scheduler
   import systolic_array_pkg::*;
#(
   parameter int TILE_DIM   = 4,
   parameter int ACC_WIDTH  = SA_ACC_WIDTH,
   parameter int ADDR_WIDTH = 16,
   parameter int DIM_WIDTH  = SA_DIM_WIDTH
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic [DIM_WIDTH-1:0] m_tiles,
   input  logic [DIM_WIDTH-1:0] n_tiles,
   input  logic [DIM_WIDTH-1:0] k_len,
   output logic                 busy,
   output logic                 done,
   sa_tile_scheduler_if.master  bus,
   output logic [DIM_WIDTH-1:0] blk_row_idx,
   output logic [DIM_WIDTH-1:0] blk_col_idx
);
   localparam int FLUSH_CYCLES = 2 * (TILE_DIM - 1);
   localparam int FW = $clog2(FLUSH_CYCLES + 1);

   systolic_array_state_t state, state_next;
   logic [DIM_WIDTH-1:0]  m_lat, n_lat, k_lat, k_cnt;
   logic [DIM_WIDTH-1:0]  blk_row, blk_col;
   logic [FW-1:0]         flush_cnt;
   logic                  beat, k_last, flush_last, tile_last, col_last;
   logic                  drain_go, drain_last, wr_valid;
   logic [ADDR_WIDTH-1:0] wr_addr;
   logic [ACC_WIDTH-1:0]  wr_data;

   assign beat       = (state == SA_STREAM) && bus.feed_valid;
   assign k_last     = beat && (k_cnt == k_lat - DIM_WIDTH'(1));
   assign flush_last = (state == SA_FLUSH) && (flush_cnt == FW'(FLUSH_CYCLES - 1));
   assign col_last   = (blk_col == n_lat - DIM_WIDTH'(1));
   assign tile_last  = col_last && (blk_row == m_lat - DIM_WIDTH'(1));

   // State register.
   always_ff @(posedge clk) begin
      if (rst) state <= SA_IDLE;
      else     state <= state_next;
   end

   // Next-state and control outputs. A job with any zero dimension goes
   // straight to FINI so the top FSM still sees its done pulse.
   always_comb begin
      state_next      = state;
      busy            = 1'b1;
      done            = 1'b0;
      bus.feed_ready  = 1'b0;
      bus.arr_enb     = 1'b0;
      bus.arr_clear   = 1'b0;
      bus.arr_zero_in = 1'b0;
      drain_go        = 1'b0;
      case (state)
         SA_IDLE: begin
            busy = 1'b0;
            if (start) begin
               if (m_tiles == '0 || n_tiles == '0 || k_len == '0) state_next = SA_FINI;
               else                                               state_next = SA_CLEAR;
            end
         end
         SA_CLEAR: begin
            bus.arr_clear = 1'b1;
            state_next    = SA_STREAM;
         end
         SA_STREAM: begin
            bus.feed_ready = bus.feed_valid;
            bus.arr_enb    = bus.feed_valid;
            if (k_last) state_next = SA_FLUSH;
         end
         SA_FLUSH: begin
            bus.arr_enb     = 1'b1;
            bus.arr_zero_in = 1'b1;
            if (flush_last) state_next = SA_DRAIN;
         end
         SA_DRAIN: begin
            drain_go = 1'b1;
            if (drain_last) state_next = tile_last ? SA_FINI : SA_CLEAR;
         end
         SA_FINI: begin
            done       = 1'b1;
            state_next = SA_IDLE;
         end
         default: begin
            busy       = 1'b0;
            state_next = SA_IDLE;
         end
      endcase
   end

   // Job dimensions, beat/flush counters and the tile position. Counters are
   // rearmed in CLEAR so every tile sees fresh counts.
   always_ff @(posedge clk) begin
      if (rst) begin
         m_lat     <= '0;
         n_lat     <= '0;
         k_lat     <= '0;
         k_cnt     <= '0;
         flush_cnt <= '0;
         blk_row   <= '0;
         blk_col   <= '0;
      end else begin
         case (state)
            SA_IDLE: begin
               if (start) begin
                  m_lat <= m_tiles;
                  n_lat <= n_tiles;
                  k_lat <= k_len;
               end
            end
            SA_CLEAR: begin
               k_cnt     <= '0;
               flush_cnt <= '0;
            end
            SA_STREAM: if (beat) k_cnt <= k_cnt + DIM_WIDTH'(1);
            SA_FLUSH:  flush_cnt <= flush_cnt + FW'(1);
            SA_DRAIN: begin
               if (drain_last && !tile_last) begin
                  if (col_last) begin
                     blk_col <= '0;
                     blk_row <= blk_row + DIM_WIDTH'(1);
                  end else begin
                     blk_col <= blk_col + DIM_WIDTH'(1);
                  end
               end
            end
            SA_FINI: begin
               blk_row <= '0;
               blk_col <= '0;
            end
            default: ;
         endcase
      end
   end

   sa_drain_sequencer #(
      .TILE_DIM   (TILE_DIM),
      .ACC_WIDTH  (ACC_WIDTH),
      .ADDR_WIDTH (ADDR_WIDTH),
      .DIM_WIDTH  (DIM_WIDTH)
   ) u_drain (
      .clk        (clk),
      .rst        (rst),
      .drain_go   (drain_go),
      .blk_row    (blk_row),
      .blk_col    (blk_col),
      .n_tiles    (n_lat),
      .arr_out    (bus.arr_out),
      .wr_ready   (bus.wr_ready),
      .wr_valid   (wr_valid),
      .wr_addr    (wr_addr),
      .wr_data    (wr_data),
      .drain_last (drain_last)
   );

   assign bus.wr_valid = wr_valid;
   assign bus.wr_addr  = wr_addr;
   assign bus.wr_data  = wr_data;
   assign blk_row_idx  = blk_row;
   assign blk_col_idx  = blk_col;

endmodule

// File: tb/tb_sa_tile_scheduler.sv
// Scoreboard bench for sa_tile_scheduler with a 2x2 array. Each job pushes its
// expected tiles, writes and per-job totals into queues; an independent
// monitor compares them against whatever the DUT presents.
`timescale 1ns/1ps
module tb_sa_tile_scheduler;
   localparam int T   = 2;
   localparam int AW  = 32;
   localparam int ADW = 16;
   localparam int DW  = 16;
   localparam int NE  = T * T;

   typedef struct { logic [31:0] addr; logic [31:0] data; } wr_t;
   typedef struct { int row; int col; } tile_t;
   typedef struct {
      int timed; int kLen; int feeds; int clears; int writes;
      int doneCyc; int clearCyc; int feedCyc; int zeroCyc; int wrCyc;
   } job_t;

   logic          clk = 1'b0;
   logic          rst, start, busy, done;
   logic [DW-1:0] m_tiles, n_tiles, k_len, blk_row_idx, blk_col_idx;

   sa_tile_scheduler_if #(.TILE_DIM(T), .ACC_WIDTH(AW), .ADDR_WIDTH(ADW)) bus ();

   sa_tile_scheduler #(.TILE_DIM(T), .ACC_WIDTH(AW), .ADDR_WIDTH(ADW), .DIM_WIDTH(DW)) dut (
      .clk(clk), .rst(rst), .start(start), .m_tiles(m_tiles), .n_tiles(n_tiles),
      .k_len(k_len), .busy(busy), .done(done), .bus(bus.master),
      .blk_row_idx(blk_row_idx), .blk_col_idx(blk_col_idx)
   );

   always #5 clk = ~clk;

   wr_t   wrQ[$];
   tile_t tileQ[$];
   job_t  jobQ[$];
   int checks = 0, errors = 0, cyc = 0;
   int feedMode = 0, readyMode = 0, stallLeft = 0, stalledTile = 0;
   int jobFeed, jobClear, jobWr, firstClear, firstFeed, firstZero, firstWr;
   int tileFeed = 0, tileAcc = 0, zeroLen = 0, doneCnt = 0;
   logic prevZero = 1'b0, stallPending = 1'b0;
   logic [31:0] heldAddr, heldData;
   tile_t monTile;
   wr_t   monWr;
   job_t  monJob;

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
      end
   endtask

   task automatic reportFail(input string name);
      checks++;
      errors++;
      $display("[TB] FAIL %s: event not expected by the model (t=%0t)", name, $time);
   endtask

   task automatic resetJobStats();
      jobFeed = 0; jobClear = 0; jobWr = 0;
      firstClear = -1; firstFeed = -1; firstZero = -1; firstWr = -1;
   endtask

   always @(posedge clk) cyc <= cyc + 1;

   // Input drivers for the feeders and the output buffer.
   initial begin
      forever begin
         @(posedge clk); #1;
         case (feedMode)
            0:       bus.feed_valid = 1'b1;
            1:       bus.feed_valid = ~bus.feed_valid;
            default: bus.feed_valid = 1'($urandom_range(0, 1));
         endcase
         case (readyMode)
            0: bus.wr_ready = 1'b1;
            1: bus.wr_ready = ($urandom_range(0, 3) != 0);
            default: begin
               if (bus.wr_valid && tileAcc == 1 && !stalledTile[0] && stallLeft == 0) begin
                  stallLeft   = 3;
                  stalledTile = 1;
               end
               if (stallLeft > 0) begin
                  bus.wr_ready = 1'b0;
                  stallLeft--;
               end else begin
                  bus.wr_ready = 1'b1;
               end
            end
         endcase
      end
   end

   // Monitor: samples mid-cycle and checks every DUT output against queues.
   initial begin
      resetJobStats();
      forever begin
         @(negedge clk);
         if (rst !== 1'b0) begin
            stallPending = 1'b0;
            prevZero     = 1'b0;
         end else begin
            if (bus.arr_clear) begin
               jobClear++;
               tileFeed = 0; tileAcc = 0; stalledTile = 0;
               if (firstClear < 0) firstClear = cyc;
               if (tileQ.size() == 0) reportFail("unexpected_tile");
               else begin
                  monTile = tileQ.pop_front();
                  checkOutput("tile_row", 32'(blk_row_idx), monTile.row);
                  checkOutput("tile_col", 32'(blk_col_idx), monTile.col);
               end
            end
            if (bus.feed_ready) begin
               jobFeed++; tileFeed++;
               if (firstFeed < 0) firstFeed = cyc;
               checkOutput("feed_ready_needs_valid", 32'(bus.feed_valid), 1);
            end
            checkOutput("arr_enb", 32'(bus.arr_enb), 32'(bus.feed_ready | bus.arr_zero_in));
            if (bus.arr_zero_in) begin
               if (!prevZero) begin
                  if (firstZero < 0) firstZero = cyc;
                  checkOutput("flush_after_k_beats", tileFeed, (jobQ.size() > 0) ? jobQ[0].kLen : -1);
                  zeroLen = 0;
               end
               zeroLen++;
            end else if (prevZero) begin
               checkOutput("flush_len", zeroLen, 2 * (T - 1));
            end
            prevZero = bus.arr_zero_in;
            if (stallPending) begin
               if (!bus.wr_valid) reportFail("wr_valid_dropped");
               else begin
                  checkOutput("stall_addr", 32'(bus.wr_addr), heldAddr);
                  checkOutput("stall_data", bus.wr_data, heldData);
               end
            end
            stallPending = 1'b0;
            if (bus.wr_valid) begin
               if (firstWr < 0) firstWr = cyc;
               checkOutput("feed_ready_in_drain", 32'(bus.feed_ready), 0);
               if (bus.wr_ready) begin
                  jobWr++; tileAcc++;
                  if (wrQ.size() == 0) reportFail("unexpected_write");
                  else begin
                     monWr = wrQ.pop_front();
                     checkOutput("wr_addr", 32'(bus.wr_addr), monWr.addr);
                     checkOutput("wr_data", bus.wr_data, monWr.data);
                  end
               end else begin
                  stallPending = 1'b1;
                  heldAddr     = 32'(bus.wr_addr);
                  heldData     = bus.wr_data;
               end
            end
            if (done) begin
               doneCnt++;
               if (jobQ.size() == 0) reportFail("unexpected_done");
               else begin
                  monJob = jobQ.pop_front();
                  checkOutput("busy_at_done", 32'(busy), 1);
                  checkOutput("job_feeds", jobFeed, monJob.feeds);
                  checkOutput("job_clears", jobClear, monJob.clears);
                  checkOutput("job_writes", jobWr, monJob.writes);
                  checkOutput("writes_left", wrQ.size(), 0);
                  if (monJob.timed != 0) begin
                     checkOutput("done_cycle", cyc, monJob.doneCyc);
                     checkOutput("clear_cycle", firstClear, monJob.clearCyc);
                     checkOutput("feed_cycle", firstFeed, monJob.feedCyc);
                     checkOutput("flush_cycle", firstZero, monJob.zeroCyc);
                     checkOutput("write_cycle", firstWr, monJob.wrCyc);
                  end
               end
               resetJobStats();
            end
         end
      end
   end

   // Issues one job: builds the expected tile/write sequence from the matrix
   // layout, then pulses start and waits (bounded) for done.
   task automatic applyStimulus(input int m, input int n, input int k, input int fm,
                                input int rm, input int midStart, input int fixedData);
      job_t        j;
      int          c0, tiles, base, a;
      logic [31:0] words[NE];
      for (int e = 0; e < NE; e++) begin
         words[e] = (fixedData != 0) ? 32'(e + 1) : $urandom;
         bus.arr_out[e*AW +: AW] = words[e];
      end
      feedMode  = fm;
      readyMode = rm;
      tiles = (m > 0 && n > 0 && k > 0) ? m * n : 0;
      if (tiles > 0)
         for (int r = 0; r < m; r++)
            for (int c = 0; c < n; c++) begin
               tileQ.push_back('{row: r, col: c});
               for (int e = 0; e < NE; e++) begin
                  a = ((r * T + e / T) * (n * T) + c * T + e % T) % 65536;
                  wrQ.push_back('{addr: 32'(a), data: words[e]});
               end
            end
      @(posedge clk); #1;
      c0 = cyc;
      j.timed  = (fm == 0 && rm == 0) ? 1 : 0;
      j.kLen   = k;
      j.feeds  = tiles * k;
      j.clears = tiles;
      j.writes = tiles * NE;
      if (tiles == 0) begin
         j.doneCyc = c0 + 1;
         j.clearCyc = -1; j.feedCyc = -1; j.zeroCyc = -1; j.wrCyc = -1;
      end else begin
         j.clearCyc = c0 + 1;
         j.feedCyc  = c0 + 2;
         j.zeroCyc  = c0 + 2 + k;
         j.wrCyc    = c0 + 2 + k + 2 * (T - 1);
         j.doneCyc  = c0 + 1 + tiles * (1 + k + 2 * (T - 1) + NE);
      end
      jobQ.push_back(j);
      base    = doneCnt;
      m_tiles = DW'(m); n_tiles = DW'(n); k_len = DW'(k);
      start   = 1'b1;
      @(posedge clk); #1;
      start   = 1'b0;
      m_tiles = DW'($urandom); n_tiles = DW'($urandom); k_len = DW'($urandom);
      if (midStart != 0 && tiles > 0) begin
         start = 1'b1;
         @(posedge clk); #1;
         start = 1'b0;
      end
      for (int i = 0; i < 3000 && doneCnt == base; i++) @(posedge clk);
      #1;
      if (doneCnt == base) begin
         reportFail("done_timeout");
         doReset();
      end else begin
         checkOutput("idle_after_done", 32'(busy), 0);
      end
   endtask

   task automatic doReset();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      wrQ.delete(); tileQ.delete(); jobQ.delete();
      stallPending = 1'b0; tileAcc = 0; tileFeed = 0;
      resetJobStats();
   endtask

   // Aborts a single-tile job while element 2 is on the write channel.
   task automatic abortInDrain();
      int i;
      int target;
      target = jobWr + 2;
      for (int e = 0; e < NE; e++) bus.arr_out[e*AW +: AW] = $urandom;
      feedMode = 0; readyMode = 0;
      for (int e = 0; e < NE; e++) wrQ.push_back('{addr: 32'(e), data: bus.arr_out[e*AW +: AW]});
      tileQ.push_back('{row: 0, col: 0});
      jobQ.push_back('{timed: 0, kLen: 1, feeds: 1, clears: 1, writes: NE,
                       doneCyc: 0, clearCyc: 0, feedCyc: 0, zeroCyc: 0, wrCyc: 0});
      @(posedge clk); #1;
      m_tiles = 1; n_tiles = 1; k_len = 1; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      i = 0;
      while (jobWr != target && i < 200) begin
         @(posedge clk); #1;
         i++;
      end
      if (jobWr != target) reportFail("abort_wait_timeout");
      checkOutput("abort_presenting_e2", 32'(bus.wr_addr), 2);
      rst = 1'b1;
      @(posedge clk); #1;
      checkOutput("abort_busy", 32'(busy), 0);
      checkOutput("abort_wr_valid", 32'(bus.wr_valid), 0);
      checkOutput("abort_done", 32'(done), 0);
      checkOutput("abort_row", 32'(blk_row_idx), 0);
      checkOutput("abort_col", 32'(blk_col_idx), 0);
      rst = 1'b0;
      wrQ.delete(); tileQ.delete(); jobQ.delete();
      stallPending = 1'b0; tileAcc = 0; tileFeed = 0;
      resetJobStats();
      repeat (3) @(posedge clk);
      #1;
      checkOutput("abort_no_done_later", 32'(busy | done), 0);
   endtask

   initial begin
      rst = 1'b1; start = 1'b0;
      m_tiles = '0; n_tiles = '0; k_len = '0;
      bus.feed_valid = 1'b0; bus.wr_ready = 1'b0; bus.arr_out = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      checkOutput("reset_busy", 32'(busy), 0);
      checkOutput("reset_done", 32'(done), 0);
      checkOutput("reset_wr_valid", 32'(bus.wr_valid), 0);
      checkOutput("reset_arr_clear", 32'(bus.arr_clear), 0);
      checkOutput("reset_arr_enb", 32'(bus.arr_enb), 0);
      checkOutput("reset_row", 32'(blk_row_idx), 0);
      checkOutput("reset_col", 32'(blk_col_idx), 0);
      @(posedge clk); #1;
      rst = 1'b0;

      $display("[TB] single tile, exact timing");
      applyStimulus(1, 1, 3, 0, 0, 0, 1);
      $display("[TB] 2x3 grid, k=1");
      applyStimulus(2, 3, 1, 0, 0, 0, 0);
      $display("[TB] write back-pressure on element 1");
      applyStimulus(1, 2, 2, 0, 2, 0, 0);
      $display("[TB] toggling feed, k=4");
      applyStimulus(1, 1, 4, 1, 0, 0, 0);
      $display("[TB] zero dimensions");
      applyStimulus(1, 1, 0, 0, 0, 0, 0);
      applyStimulus(0, 2, 3, 0, 0, 0, 0);
      $display("[TB] start ignored while busy");
      applyStimulus(2, 1, 2, 0, 0, 1, 0);
      $display("[TB] reset during drain");
      abortInDrain();
      applyStimulus(1, 1, 2, 0, 0, 0, 0);
      $display("[TB] randomized jobs");
      for (int i = 0; i < 12; i++)
         applyStimulus($urandom_range(1, 3), $urandom_range(1, 3), $urandom_range(1, 5),
                       $urandom_range(0, 2), $urandom_range(0, 2), $urandom_range(0, 1), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
